contador_ms_16b: RTL and testbench

- Millisecond counter that sits directly upstream of the 16-bit equality comparator and drives its first operand.
- Divides the system clock down to a 1 ms tick and accumulates elapsed milliseconds in a 16-bit register.
- Provides start/pause/clear control through a 3-state FSM, plus tick and overflow pulses for downstream logic.

---
 rtl/contador_ms_16b_pkg.sv | 12 +
 rtl/contador_ms_16b_divisor_ms.sv | 41 ++++
 rtl/contador_ms_16b.sv | 115 +++++++++++
 tb/tb_contador_ms_16b.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/contador_ms_16b_pkg.sv
// Shared definitions for the millisecond counter: FSM state encoding and counter width.
package contador_ms_16b_pkg;

    localparam int unsigned ANCHO_CUENTA = 16;

    typedef enum logic [1:0] {
        EST_REPOSO   = 2'b00,
        EST_CONTANDO = 2'b01,
        EST_PAUSA    = 2'b10
    } estado_e;

endpackage

// File: rtl/contador_ms_16b_divisor_ms.sv
// Clock prescaler: counts enabled cycles modulo CICLOS_POR_MS and flags the terminal count.
// The clear input overrides the enable and suppresses the terminal-count flag.
module contador_ms_16b_divisor_ms #(
    parameter int unsigned CICLOS_POR_MS = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic fin_o
);

    localparam int unsigned AnchoPre = (CICLOS_POR_MS > 2) ? $clog2(CICLOS_POR_MS) : 1;
    localparam logic [AnchoPre-1:0] Terminal = AnchoPre'(CICLOS_POR_MS - 1);

    logic [AnchoPre-1:0] pre_q, pre_d;
    logic                fin;

    assign fin   = en_i && !clr_i && (pre_q == Terminal);
    assign fin_o = fin;

    // Next prescaler value: clear wins, then wrap on terminal count, else advance when enabled.
    always_comb begin
        pre_d = pre_q;
        if (clr_i) begin
            pre_d = '0;
        end else if (en_i) begin
            pre_d = fin ? '0 : pre_q + AnchoPre'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/contador_ms_16b.sv
// Millisecond counter with start/pause/clear FSM, tick and overflow pulses.
// Optional build macro CONTADOR_SATURA_EN: saturate at 0xFFFF and park in PAUSA instead of wrapping.
module contador_ms_16b
    import contador_ms_16b_pkg::*;
#(
    parameter int unsigned CICLOS_POR_MS = 100000,
    parameter int unsigned ANCHO         = ANCHO_CUENTA
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iniciar,
    input  logic             detener,
    input  logic             limpiar,
    output logic [ANCHO-1:0] cuenta,
    output logic             tick_ms,
    output logic             desborde,
    output logic [1:0]       estado
);

`ifdef CONTADOR_SATURA_EN
    localparam bit Satura = 1'b1;
`else
    localparam bit Satura = 1'b0;
`endif

    estado_e          estado_q, estado_d;
    logic [ANCHO-1:0] cuenta_q, cuenta_d;
    logic             tick_q, tick_d;
    logic             desb_q, desb_d;

    logic pre_en, pre_clr, fin_ms, cuenta_max, satura_ahora;

    assign cuenta_max   = &cuenta_q;
    // Terminal count while already at full scale in saturating builds.
    assign satura_ahora = Satura && fin_ms && cuenta_max;

    assign pre_en  = (estado_q == EST_CONTANDO);
    // Entering CONTANDO from REPOSO always starts a fresh millisecond.
    assign pre_clr = limpiar || ((estado_q == EST_REPOSO) && iniciar);

    contador_ms_16b_divisor_ms #(
        .CICLOS_POR_MS(CICLOS_POR_MS)
    ) u_divisor (
        .clk  (clk),
        .rst_n(rst_n),
        .en_i (pre_en),
        .clr_i(pre_clr),
        .fin_o(fin_ms)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= EST_REPOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // FSM next state; limpiar beats detener beats iniciar.
    always_comb begin
        estado_d = estado_q;
        if (limpiar) begin
            estado_d = EST_REPOSO;
        end else begin
            unique case (estado_q)
                EST_REPOSO: begin
                    if (iniciar) estado_d = EST_CONTANDO;
                end
                EST_CONTANDO: begin
                    if (detener || satura_ahora) estado_d = EST_PAUSA;
                end
                EST_PAUSA: begin
                    if (iniciar && !(Satura && cuenta_max)) estado_d = EST_CONTANDO;
                end
                default: estado_d = EST_REPOSO;
            endcase
        end
    end

    // Accumulator and pulse outputs; a terminal count still completes even if detener is set.
    always_comb begin
        cuenta_d = cuenta_q;
        tick_d   = 1'b0;
        desb_d   = 1'b0;
        if (limpiar) begin
            cuenta_d = '0;
        end else if (satura_ahora) begin
            desb_d = 1'b1;
        end else if (fin_ms) begin
            cuenta_d = cuenta_q + ANCHO'(1);
            tick_d   = 1'b1;
            desb_d   = cuenta_max;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta_q <= '0;
            tick_q   <= 1'b0;
            desb_q   <= 1'b0;
        end else begin
            cuenta_q <= cuenta_d;
            tick_q   <= tick_d;
            desb_q   <= desb_d;
        end
    end

    assign cuenta   = cuenta_q;
    assign tick_ms  = tick_q;
    assign desborde = desb_q;
    assign estado   = estado_q;

endmodule

// File: tb/tb_contador_ms_16b.sv
// Self-checking bench for contador_ms_16b with a small prescaler and a behavioural reference.
module tb_contador_ms_16b;

    localparam int unsigned N = 4;
`ifdef CONTADOR_SATURA_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        iniciar = 1'b0;
    logic        detener = 1'b0;
    logic        limpiar = 1'b0;
    logic [15:0] cuenta;
    logic        tick_ms;
    logic        desborde;
    logic [1:0]  estado;

    contador_ms_16b #(
        .CICLOS_POR_MS(N),
        .ANCHO        (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .iniciar (iniciar),
        .detener (detener),
        .limpiar (limpiar),
        .cuenta  (cuenta),
        .tick_ms (tick_ms),
        .desborde(desborde),
        .estado  (estado)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int ticks    = 0;

    // Reference: elapsed whole ms, cycles into the current ms, mode (0 idle, 1 run, 2 paused).
    int m_cuenta;
    int m_fase;
    int m_modo;
    int m_tick;
    int m_desb;

    function automatic void modelo_reset();
        m_cuenta = 0;
        m_fase   = 0;
        m_modo   = 0;
        m_tick   = 0;
        m_desb   = 0;
    endfunction

    function automatic void modelo_paso(bit ini, bit det, bit lim);
        m_tick = 0;
        m_desb = 0;
        if (lim) begin
            m_modo   = 0;
            m_cuenta = 0;
            m_fase   = 0;
        end else if (m_modo == 0) begin
            if (ini) begin
                m_modo = 1;
                m_fase = 0;
            end
        end else if (m_modo == 1) begin
            m_fase = m_fase + 1;
            if (m_fase == N) begin
                m_fase = 0;
                if (SAT && m_cuenta == 65535) begin
                    m_desb = 1;
                    m_modo = 2;
                end else begin
                    m_cuenta = (m_cuenta + 1) % 65536;
                    m_tick   = 1;
                    m_desb   = (m_cuenta == 0) ? 1 : 0;
                end
            end
            if (det) m_modo = 2;
        end else begin
            if (ini && !(SAT && m_cuenta == 65535)) m_modo = 1;
        end
    endfunction

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        assert (obs === esp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, esp);
        end
    endtask

    task automatic comparar_todo(input string tag);
        chequear({tag, ".cuenta"}, {16'h0, cuenta}, m_cuenta);
        chequear({tag, ".tick_ms"}, {31'h0, tick_ms}, m_tick);
        chequear({tag, ".desborde"}, {31'h0, desborde}, m_desb);
        chequear({tag, ".estado"}, {30'h0, estado}, m_modo);
    endtask

    // Drive one cycle of control pulses, advance the model, sample 1 ns after the edge.
    task automatic ciclo(input bit ini, input bit det, input bit lim);
        @(negedge clk);
        iniciar = ini;
        detener = det;
        limpiar = lim;
        @(posedge clk);
        modelo_paso(ini, det, lim);
        #1;
        comparar_todo("ciclo");
        if (tick_ms === 1'b1) ticks++;
        iniciar = 1'b0;
        detener = 1'b0;
        limpiar = 1'b0;
    endtask

    // Run idle cycles until the model reports a tick reaching objetivo (bounded).
    task automatic esperar_tick(input int objetivo);
        for (int i = 0; i < 200; i++) begin
            ciclo(1'b0, 1'b0, 1'b0);
            if (m_tick == 1 && m_cuenta == objetivo) break;
        end
    endtask

    task automatic precargar(input logic [15:0] valor);
        force dut.cuenta_q = valor;
        #1;
        release dut.cuenta_q;
        m_cuenta = valor;
    endtask

    int k;
    logic [15:0] c_ov;
    logic        t_ov;
    logic        d_ov;
    logic [1:0]  e_ov;

    initial begin
        modelo_reset();
        // Asynchronous reset with no clock edge involved.
        #1 rst_n = 1'b0;
        #2;
        comparar_todo("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Free run: 10 ms in 40 cycles.
        ciclo(1'b1, 1'b0, 1'b0);
        ticks = 0;
        repeat (40) ciclo(1'b0, 1'b0, 1'b0);
        chequear("run40.ticks", ticks, 10);
        chequear("run40.cuenta", {16'h0, cuenta}, 10);
        chequear("run40.estado", {30'h0, estado}, 1);

        // Pause mid-millisecond and resume with the partial ms retained.
        ciclo(1'b0, 1'b0, 1'b1);
        ciclo(1'b1, 1'b0, 1'b0);
        esperar_tick(5);
        chequear("pausa.cuenta5", {16'h0, cuenta}, 5);
        ciclo(1'b0, 1'b0, 1'b0);
        ciclo(1'b0, 1'b1, 1'b0);
        ticks = 0;
        repeat (20) ciclo(1'b0, 1'b0, 1'b0);
        chequear("pausa.ticks", ticks, 0);
        chequear("pausa.estado", {30'h0, estado}, 2);
        ciclo(1'b1, 1'b0, 1'b0);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            ciclo(1'b0, 1'b0, 1'b0);
            k++;
            if (tick_ms === 1'b1) break;
        end
        chequear("reanuda.latencia", k, 2);
        chequear("reanuda.cuenta", {16'h0, cuenta}, 6);

        // Top of range: wrap (or saturate).
        ciclo(1'b0, 1'b0, 1'b1);
        ciclo(1'b1, 1'b0, 1'b0);
        precargar(16'hFFFD);
        c_ov = 16'h5555;
        t_ov = 1'b0;
        d_ov = 1'b0;
        e_ov = 2'b11;
        for (int i = 0; i < 20; i++) begin
            ciclo(1'b0, 1'b0, 1'b0);
            if (desborde === 1'b1) begin
                c_ov = cuenta;
                t_ov = tick_ms;
                d_ov = desborde;
                e_ov = estado;
                break;
            end
        end
        chequear("tope.desborde", {31'h0, d_ov}, 1);
        chequear("tope.cuenta", {16'h0, c_ov}, SAT ? 32'hFFFF : 32'h0);
        chequear("tope.tick", {31'h0, t_ov}, SAT ? 32'h0 : 32'h1);
        chequear("tope.estado", {30'h0, e_ov}, SAT ? 32'h2 : 32'h1);
        ciclo(1'b1, 1'b0, 1'b0);
        repeat (6) ciclo(1'b0, 1'b0, 1'b0);

        // limpiar and iniciar together: limpiar wins.
        ciclo(1'b1, 1'b0, 1'b1);
        ticks = 0;
        repeat (12) ciclo(1'b0, 1'b0, 1'b0);
        chequear("limpia.ticks", ticks, 0);
        chequear("limpia.estado", {30'h0, estado}, 0);
        chequear("limpia.cuenta", {16'h0, cuenta}, 0);

        // Asynchronous reset mid-prescale at 0x1234.
        ciclo(1'b1, 1'b0, 1'b0);
        precargar(16'h1234);
        ciclo(1'b0, 1'b0, 1'b0);
        ciclo(1'b0, 1'b0, 1'b0);
        chequear("prereset.cuenta", {16'h0, cuenta}, 32'h1234);
        #2 rst_n = 1'b0;
        #1;
        modelo_reset();
        chequear("rst_async.cuenta", {16'h0, cuenta}, 0);
        chequear("rst_async.tick", {31'h0, tick_ms}, 0);
        chequear("rst_async.desborde", {31'h0, desborde}, 0);
        chequear("rst_async.estado", {30'h0, estado}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // detener on the terminal-count edge at cuenta=7.
        ciclo(1'b1, 1'b0, 1'b0);
        esperar_tick(7);
        chequear("det_fin.cuenta7", {16'h0, cuenta}, 7);
        repeat (3) ciclo(1'b0, 1'b0, 1'b0);
        ciclo(1'b0, 1'b1, 1'b0);
        chequear("det_fin.cuenta", {16'h0, cuenta}, 8);
        chequear("det_fin.tick", {31'h0, tick_ms}, 1);
        chequear("det_fin.estado", {30'h0, estado}, 2);

        // Random control pulses against the reference.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            ciclo(r >= 10 && r < 25, r >= 3 && r < 10, r < 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
